// File: rtl/sata_rx_prim_decoder.sv
// SATA RX primitive decoder: classifies transceiver dwords, tracks ALIGN-based
// dword lock and expands CONT runs into repeated primitive reports.
module sata_rx_prim_decoder #(
  parameter int unsigned LOCK_ALIGNS = 3,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic [3:0]  rx_syncstatus,
  output logic        aligned,
  output logic        prim_valid,
  output logic [4:0]  prim_code,
  output logic        data_valid,
  output logic [31:0] data_out,
  output logic        code_err
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam logic [4:0] P_ALIGN = 5'd0;
  localparam logic [4:0] P_CONT  = 5'd12;

  localparam logic [3:0] LOCK_N = 4'(LOCK_ALIGNS);
  localparam logic [3:0] UNL_N  = 4'(UNLOCK_ERRS);

  logic [0:0] state_q, state_d;
  logic [3:0] align_q, align_d, align_inc;
  logic [3:0] err_q, err_d, err_inc;
  logic       cont_q, cont_d;
  logic       hold_v_q, hold_v_d;
  logic [4:0] hold_q, hold_d;

  logic        aligned_d, pv_d, dv_d, ce_d;
  logic [4:0]  pc_d;
  logic [31:0] do_d;

  logic       good, is_prim, is_data, is_align, bad, prim_hit;
  logic [4:0] code;

  always_comb begin
    prim_hit = 1'b1;
    code     = '0;
    case (rx_data)
      32'h7B4A4ABC: code = 5'd0;
      32'hB5B5957C: code = 5'd1;
      32'h5757B57C: code = 5'd2;
      32'h4A4A957C: code = 5'd3;
      32'h5555B57C: code = 5'd4;
      32'h3535B57C: code = 5'd5;
      32'h5656B57C: code = 5'd6;
      32'h3737B57C: code = 5'd7;
      32'hD5D5B57C: code = 5'd8;
      32'h5858B57C: code = 5'd9;
      32'hD5D5AA7C: code = 5'd10;
      32'h9595AA7C: code = 5'd11;
      32'h9999AA7C: code = 5'd12;
      32'h3636B57C: code = 5'd13;
      32'h1717B57C: code = 5'd14;
      32'h7575957C: code = 5'd15;
      32'h9595957C: code = 5'd16;
      32'hF5F5957C: code = 5'd17;
      default:      prim_hit = 1'b0;
    endcase
  end

  assign good      = (rx_syncstatus == 4'hF);
  assign is_prim   = good && (rx_datak == 4'b0001) && prim_hit;
  assign is_data   = good && (rx_datak == 4'b0000);
  assign is_align  = is_prim && (code == P_ALIGN);
  assign bad       = !(is_prim || is_data);
  assign align_inc = (align_q == 4'hF) ? align_q : align_q + 4'd1;
  assign err_inc   = (err_q == 4'hF) ? err_q : err_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    align_d  = align_q;
    err_d    = err_q;
    cont_d   = cont_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    pv_d     = 1'b0;
    pc_d     = '0;
    dv_d     = 1'b0;
    do_d     = '0;
    ce_d     = bad;
    if (state_q == ST_UNLOCKED) begin
      if (is_align) begin
        pv_d = 1'b1;
        pc_d = P_ALIGN;
        if (align_inc >= LOCK_N) begin
          state_d = ST_LOCKED;
          align_d = '0;
          err_d   = '0;
        end else begin
          align_d = align_inc;
        end
      end else begin
        align_d = '0;
      end
    end else if (bad) begin
      // Losing lock discards any CONT context so a relock starts clean.
      if (err_inc >= UNL_N) begin
        state_d  = ST_UNLOCKED;
        err_d    = '0;
        align_d  = '0;
        cont_d   = 1'b0;
        hold_v_d = 1'b0;
        hold_d   = '0;
      end else begin
        err_d = err_inc;
      end
    end else begin
      err_d = '0;
      if (is_data) begin
        if (cont_q) begin
          pv_d = 1'b1;
          pc_d = hold_q;
        end else begin
          dv_d = 1'b1;
          do_d = rx_data;
        end
      end else begin
        pv_d = 1'b1;
        pc_d = code;
        if (code == P_CONT) begin
          if (hold_v_q) cont_d = 1'b1;
        end else if (code != P_ALIGN) begin
          hold_d   = code;
          hold_v_d = 1'b1;
          cont_d   = 1'b0;
        end
      end
    end
    aligned_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_UNLOCKED;
      align_q    <= '0;
      err_q      <= '0;
      cont_q     <= 1'b0;
      hold_v_q   <= 1'b0;
      hold_q     <= '0;
      aligned    <= 1'b0;
      prim_valid <= 1'b0;
      prim_code  <= '0;
      data_valid <= 1'b0;
      data_out   <= '0;
      code_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      align_q    <= align_d;
      err_q      <= err_d;
      cont_q     <= cont_d;
      hold_v_q   <= hold_v_d;
      hold_q     <= hold_d;
      aligned    <= aligned_d;
      prim_valid <= pv_d;
      prim_code  <= pc_d;
      data_valid <= dv_d;
      data_out   <= do_d;
      code_err   <= ce_d;
    end
  end

endmodule

// File: tb/tb_sata_rx_prim_decoder.sv
// Bench for sata_rx_prim_decoder: directed scenarios plus random traffic
// checked against a behavioural model of the lock/CONT rules.
module tb_sata_rx_prim_decoder;

  localparam int LOCK_ALIGNS = 3;
  localparam int UNLOCK_ERRS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rx_data = '0;
  logic [3:0]  rx_datak = '0;
  logic [3:0]  rx_syncstatus = '0;
  logic        aligned, prim_valid, data_valid, code_err;
  logic [4:0]  prim_code;
  logic [31:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] prim_tab [0:17] = '{
    32'h7B4A4ABC, 32'hB5B5957C, 32'h5757B57C, 32'h4A4A957C, 32'h5555B57C,
    32'h3535B57C, 32'h5656B57C, 32'h3737B57C, 32'hD5D5B57C, 32'h5858B57C,
    32'hD5D5AA7C, 32'h9595AA7C, 32'h9999AA7C, 32'h3636B57C, 32'h1717B57C,
    32'h7575957C, 32'h9595957C, 32'hF5F5957C};

  // Model state: lock flag, run lengths, CONT flag, held primitive (-1 = none)
  bit m_locked;
  int m_aligns, m_errs, m_hold;
  bit m_cont;
  logic        e_aligned, e_pv, e_dv, e_ce;
  logic [4:0]  e_pc;
  logic [31:0] e_do;

  sata_rx_prim_decoder #(.LOCK_ALIGNS(LOCK_ALIGNS), .UNLOCK_ERRS(UNLOCK_ERRS)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_datak(rx_datak),
    .rx_syncstatus(rx_syncstatus), .aligned(aligned), .prim_valid(prim_valid),
    .prim_code(prim_code), .data_valid(data_valid), .data_out(data_out),
    .code_err(code_err));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  // -2 bad dword, -1 data dword, 0..17 primitive index
  function automatic int classify(logic [31:0] d, logic [3:0] k, logic [3:0] s);
    if (s != 4'hF) return -2;
    if (k == 4'b0000) return -1;
    if (k == 4'b0001)
      for (int i = 0; i < 18; i++) if (d == prim_tab[i]) return i;
    return -2;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_aligns = 0; m_errs = 0; m_cont = 0; m_hold = -1;
  endtask

  task automatic model_step(input logic [31:0] d, input int c);
    e_pv = 0; e_pc = '0; e_dv = 0; e_do = '0; e_ce = (c == -2);
    if (!m_locked) begin
      if (c == 0) begin
        e_pv = 1;
        m_aligns++;
        if (m_aligns >= LOCK_ALIGNS) begin m_locked = 1; m_errs = 0; end
      end else m_aligns = 0;
    end else if (c == -2) begin
      m_errs++;
      if (m_errs >= UNLOCK_ERRS) begin
        m_locked = 0; m_aligns = 0; m_cont = 0; m_hold = -1;
      end
    end else begin
      m_errs = 0;
      if (c == -1) begin
        if (m_cont) begin e_pv = 1; e_pc = 5'(m_hold); end
        else begin e_dv = 1; e_do = d; end
      end else begin
        e_pv = 1; e_pc = 5'(c);
        if (c == 12) begin
          if (m_hold >= 0) m_cont = 1;
        end else if (c != 0) begin
          m_hold = c; m_cont = 0;
        end
      end
    end
    e_aligned = m_locked;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".aligned"}, 32'(aligned), 32'(e_aligned));
    check({tag, ".prim_valid"}, 32'(prim_valid), 32'(e_pv));
    if (e_pv) check({tag, ".prim_code"}, 32'(prim_code), 32'(e_pc));
    check({tag, ".data_valid"}, 32'(data_valid), 32'(e_dv));
    if (e_dv) check({tag, ".data_out"}, data_out, e_do);
    check({tag, ".code_err"}, 32'(code_err), 32'(e_ce));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".aligned"}, 32'(aligned), 32'd0);
    check({tag, ".prim_valid"}, 32'(prim_valid), 32'd0);
    check({tag, ".prim_code"}, 32'(prim_code), 32'd0);
    check({tag, ".data_valid"}, 32'(data_valid), 32'd0);
    check({tag, ".data_out"}, data_out, 32'd0);
    check({tag, ".code_err"}, 32'(code_err), 32'd0);
  endtask

  // Drive now (caller is at a negedge), check 1 ns after the next posedge.
  task automatic apply(input string tag, input logic [31:0] d, input logic [3:0] k, input logic [3:0] s);
    rx_data = d; rx_datak = k; rx_syncstatus = s;
    model_step(d, classify(d, k, s));
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic send(input string tag, input logic [31:0] d, input logic [3:0] k, input logic [3:0] s);
    @(negedge clk);
    apply(tag, d, k, s);
  endtask

  task automatic prim(input string tag, input int idx);
    send(tag, prim_tab[idx], 4'b0001, 4'hF);
  endtask

  task automatic dat(input string tag, input logic [31:0] d);
    send(tag, d, 4'b0000, 4'hF);
  endtask

  task automatic randomize_inputs();
    rx_data = $urandom; rx_datak = 4'($urandom); rx_syncstatus = 4'($urandom);
  endtask

  // Reset already asserted by caller; hold it with random stimulus, then release into a data dword.
  task automatic finish_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); randomize_inputs();
      @(posedge clk); #1;
      check_zero({tag, ".held"});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply({tag, ".release"}, $urandom, 4'b0000, 4'hF);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    randomize_inputs();
    #1 check_zero({tag, ".async"});
    finish_reset(tag);
  endtask

  task automatic lock(input string tag);
    for (int i = 0; i < LOCK_ALIGNS; i++) prim(tag, 0);
  endtask

  initial begin
    model_reset();

    // Reset behaviour and data-only stream after release
    randomize_inputs();
    #1 check_zero("t1.por");
    finish_reset("t1");
    for (int i = 0; i < 6; i++) dat("t1.data_unlocked", $urandom);

    // Lock acquisition; an interrupted ALIGN run must not lock
    do_reset("t2a");
    lock("t2.lock");
    do_reset("t2b");
    prim("t2.a1", 0); prim("t2.a2", 0); prim("t2.sync", 1); prim("t2.a3", 0);
    prim("t2.a4", 0); prim("t2.a5", 0);

    // Data and primitives through a locked link
    do_reset("t3");
    lock("t3.lock");
    prim("t3.sof", 7); dat("t3.data", 32'h12345678); prim("t3.eof", 8);

    // CONT expansion
    prim("t4.hold", 10); prim("t4.cont", 12);
    for (int i = 0; i < 5; i++) dat("t4.filler", $urandom);
    prim("t4.align", 0);
    dat("t4.filler2", $urandom); dat("t4.filler3", $urandom);
    prim("t4.rok", 5); dat("t4.data_after", $urandom);

    // Unlock on consecutive bad dwords; a good dword resets the run
    for (int i = 0; i < 3; i++) send("t5.bad", $urandom, 4'b0000, 4'h7);
    dat("t5.good", 32'hCAFEF00D);
    prim("t5.hold", 10); prim("t5.cont", 12); dat("t5.filler", $urandom);
    for (int i = 0; i < 4; i++) send("t5.unlock", $urandom, 4'b0000, 4'h7);
    dat("t5.after_unlock", $urandom);
    lock("t5.relock");
    dat("t5.no_cont", 32'h0BADBEEF);

    // Malformed dwords and CONT with nothing held
    do_reset("t6");
    lock("t6.lock");
    send("t6.bad_k", 32'h0000007C, 4'b0001, 4'hF);
    send("t6.k_byte1", $urandom, 4'b0010, 4'hF);
    prim("t6.cont_empty", 12);
    dat("t6.data", 32'hA5A55A5A);

    // Mid-cycle asynchronous reset while locked
    @(posedge clk); #3;
    reset = 1'b0;
    #1 check_zero("t7.midcycle");
    finish_reset("t7");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 20) prim("rnd.align", 0);
      else if (r < 45) prim("rnd.prim", $urandom_range(1, 17));
      else if (r < 78) dat("rnd.data", $urandom);
      else if (r < 88) send("rnd.nosync", $urandom, 4'($urandom), 4'($urandom_range(0, 14)));
      else send("rnd.kdword", (r < 94) ? 32'($urandom) : prim_tab[$urandom_range(0, 17)],
                4'($urandom_range(2, 15)), 4'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
